ibus_fetch_bridge: RTL

- Instruction-fetch bridge directly upstream of the risac core's instruction port.
- Converts the core's address/read/wait fetch protocol into a pipelined memory-master protocol with waitrequest and readdatavalid.
- Tracks one outstanding fetch and discards stale responses after a branch.
- Holds a delivered instruction until the core's pipeline accepts it; provides a fetch timeout and a stale-fetch counter.

---
 rtl/ibus_fetch_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ibus_fetch_bridge.sv
// Instruction-fetch bridge between the core's address/read/wait port and a
// pipelined memory master with waitrequest/readdatavalid. It keeps one fetch
// outstanding, drops responses made stale by a branch, and holds the delivered
// word until the core consumes it.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no fetch in flight, waiting for core_read
// ISSUE     | mem_read asserted with req_addr until memory accepts it
// WAIT_RESP | request accepted, waiting for mem_rvalid or the timeout
// VALID     | instruction presented to the core, held while it stalls
module ibus_fetch_bridge #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              TIMEOUT = 255,
  parameter logic [DW-1:0]   NOP     = 32'h00000013,
  parameter int              CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] core_addr,
  input  logic          core_read,
  input  logic          core_stall,
  output logic [DW-1:0] core_data,
  output logic [AW-1:0] core_iaddr,
  output logic          core_wait,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  input  logic          mem_waitrequest,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          bus_err,
  output logic [CW-1:0] stale_cnt
);

  // The counter only has to reach TIMEOUT-1 before the abort fires.
  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    VALID     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic          err_q, err_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic [AW-1:0] aligned_addr;
  logic          addr_match;
  logic          unused_addr_bits;

  assign aligned_addr     = {core_addr[AW-1:2], 2'b00};
  assign addr_match       = (core_addr[AW-1:2] == req_q[AW-1:2]);
  assign unused_addr_bits = ^core_addr[1:0];

  // Next-state and datapath update; every register holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    iaddr_d = iaddr_q;
    err_d   = err_q;
    stale_d = stale_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (core_read) begin
          req_d   = aligned_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // No abort here: the request stays on the bus until accepted.
        if (!mem_waitrequest) begin
          tcnt_d  = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        tcnt_d = tcnt_q + 1'b1;
        if (mem_rvalid) begin
          if (addr_match) begin
            data_d  = mem_rdata;
            iaddr_d = req_q;
            state_d = VALID;
          end else begin
            if (stale_q != '1) stale_d = stale_q + 1'b1;
            req_d   = aligned_addr;
            state_d = ISSUE;
          end
        end else if ((TIMEOUT != 0) && (tcnt_q == TLAST)) begin
          err_d   = 1'b1;
          data_d  = NOP;
          iaddr_d = req_q;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!core_stall) begin
          if (core_read) begin
            req_d   = aligned_addr;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      data_q  <= '0;
      iaddr_q <= '0;
      err_q   <= 1'b0;
      stale_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      iaddr_q <= iaddr_d;
      err_q   <= err_d;
      stale_q <= stale_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign core_wait  = (state_q != VALID);
  assign mem_read   = (state_q == ISSUE);
  assign mem_addr   = req_q;
  assign core_data  = data_q;
  assign core_iaddr = iaddr_q;
  assign bus_err    = err_q;
  assign stale_cnt  = stale_q;

endmodule
